// File: rtl/seq_pkg.sv
// Shared definitions for the note sequencer: event-word op codes and field
// positions, FSM state encoding, and the voice-reset length limit.
package seq_pkg;

  typedef enum logic [1:0] {
    OP_NOTE = 2'b00,
    OP_WAIT = 2'b01,
    OP_MUTE = 2'b10,
    OP_END  = 2'b11
  } op_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_PULSE,
    S_DELAY
  } state_t;

  // Event word layout: [15:14] op, [13:12] voice, [11:5] key, [4:0] delay
  localparam int unsigned OP_HI  = 15;
  localparam int unsigned OP_LO  = 14;
  localparam int unsigned V_HI   = 13;
  localparam int unsigned V_LO   = 12;
  localparam int unsigned KEY_HI = 11;
  localparam int unsigned KEY_LO = 5;
  localparam int unsigned D_HI   = 4;
  localparam int unsigned D_LO   = 0;

  localparam int unsigned KEY_W = 7;
  localparam int unsigned D_W   = 5;

  // A voice reset must span every phase of the synth's slower clock.
  localparam int unsigned RST_LEN_MIN = 4;

  function automatic bit rst_len_ok(input int unsigned len);
    return len >= RST_LEN_MIN;
  endfunction

  // Timer load width: wide enough for both a delay field and RST_LEN.
  function automatic int unsigned cnt_width(input int unsigned rst_len);
    int unsigned w;
    w = $clog2(rst_len + 1);
    return (w > D_W) ? w : D_W;
  endfunction

endpackage

// File: rtl/seq_delay_timer.sv
// Down-counting timer. On load it captures d and counts d units, then
// raises done for one cycle (the cycle of the final unit).
// A unit is TICK_DIV clk cycles, or a single clk cycle when raw=1
// (used for the voice-reset pulse).
// Ports: clk, rsts (async, active-high), load, raw, d -> done.
module seq_delay_timer #(
  parameter int unsigned TICK_DIV = 78125,
  parameter int unsigned CNT_W    = 5
) (
  input  logic             clk,
  input  logic             rsts,
  input  logic             load,
  input  logic             raw,
  input  logic [CNT_W-1:0] d,
  output logic             done
);

  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] pre;
  logic [CNT_W-1:0] rem;
  logic             raw_q;

  // Prescaler restarts on every load so each delay starts on a fresh tick.
  always_ff @(posedge clk or posedge rsts) begin
    if (rsts) begin
      pre   <= '0;
      rem   <= '0;
      raw_q <= 1'b0;
    end else if (load) begin
      rem   <= d;
      raw_q <= raw;
      pre   <= raw ? '0 : PRE_TOP;
    end else if (rem != '0) begin
      if (pre == '0) begin
        rem <= rem - CNT_W'(1);
        pre <= raw_q ? '0 : PRE_TOP;
      end else begin
        pre <= pre - PRE_W'(1);
      end
    end
  end

  assign done = (rem == CNT_W'(1)) && (pre == '0);

endmodule

// File: rtl/note_sequencer.sv
// Score player: fetches 16-bit event words from a synchronous score ROM and
// drives the synth's per-voice key numbers, retrigger pulses and mutes.
// Ports: clk, rsts (async, active-high), start, stop, loop_en,
//        rom_addr/rom_data (score ROM), key0..key3, vrst0..vrst3, mute, busy.
module note_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 78125,
  parameter int unsigned RST_LEN  = 4,
  parameter int unsigned ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rsts,
  input  logic              start,
  input  logic              stop,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [6:0]        key0,
  output logic [6:0]        key1,
  output logic [6:0]        key2,
  output logic [6:0]        key3,
  output logic              vrst0,
  output logic              vrst1,
  output logic              vrst2,
  output logic              vrst3,
  output logic [3:0]        mute,
  output logic              busy
);

  localparam int unsigned CNT_W = cnt_width(RST_LEN);

  if (!rst_len_ok(RST_LEN)) begin : g_rst_len_check
    $error("note_sequencer: RST_LEN must be at least %0d", RST_LEN_MIN);
  end

  state_t           state;
  logic [KEY_W-1:0] keys [4];
  logic [3:0]       vrst;
  logic [D_W-1:0]   dly;

  op_t              ev_op;
  logic [1:0]       ev_v;
  logic [KEY_W-1:0] ev_key;
  logic [D_W-1:0]   ev_d;

  logic             tmr_load;
  logic             tmr_raw;
  logic [CNT_W-1:0] tmr_d;
  logic             tmr_done;

  assign ev_op  = op_t'(rom_data[OP_HI:OP_LO]);
  assign ev_v   = rom_data[V_HI:V_LO];
  assign ev_key = rom_data[KEY_HI:KEY_LO];
  assign ev_d   = rom_data[D_HI:D_LO];

  // The single timer serves both the reset pulse (raw cycles) and the
  // delay (ticks); it is reloaded on the edge that enters PULSE or DELAY.
  always_comb begin
    tmr_load = 1'b0;
    tmr_raw  = 1'b0;
    tmr_d    = '0;
    case (state)
      S_DECODE: begin
        if (ev_op == OP_NOTE) begin
          tmr_load = 1'b1;
          tmr_raw  = 1'b1;
          tmr_d    = CNT_W'(RST_LEN);
        end else if (ev_op != OP_END && ev_d != '0) begin
          tmr_load = 1'b1;
          tmr_d    = CNT_W'(ev_d);
        end
      end
      S_PULSE: begin
        if (tmr_done && dly != '0) begin
          tmr_load = 1'b1;
          tmr_d    = CNT_W'(dly);
        end
      end
      default: ;
    endcase
  end

  seq_delay_timer #(
    .TICK_DIV (TICK_DIV),
    .CNT_W    (CNT_W)
  ) u_timer (
    .clk  (clk),
    .rsts (rsts),
    .load (tmr_load),
    .raw  (tmr_raw),
    .d    (tmr_d),
    .done (tmr_done)
  );

  always_ff @(posedge clk or posedge rsts) begin
    if (rsts) begin
      state    <= S_IDLE;
      rom_addr <= '0;
      for (int unsigned i = 0; i < 4; i++) keys[i] <= '0;
      vrst     <= '0;
      mute     <= '1;
      busy     <= 1'b0;
      dly      <= '0;
    end else if (stop && state != S_IDLE) begin
      vrst  <= '0;
      mute  <= '1;
      busy  <= 1'b0;
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            rom_addr <= '0;
            busy     <= 1'b1;
            state    <= S_FETCH;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          dly <= ev_d;
          case (ev_op)
            OP_NOTE: begin
              keys[ev_v] <= ev_key;
              vrst[ev_v] <= 1'b1;
              mute[ev_v] <= 1'b0;
              state      <= S_PULSE;
            end
            OP_WAIT, OP_MUTE: begin
              if (ev_op == OP_MUTE) mute[ev_v] <= ev_key[0];
              if (ev_d == '0) begin
                rom_addr <= rom_addr + ADDR_W'(1);
                state    <= S_FETCH;
              end else begin
                state <= S_DELAY;
              end
            end
            default: begin
              if (loop_en) begin
                rom_addr <= '0;
                state    <= S_FETCH;
              end else begin
                mute  <= '1;
                busy  <= 1'b0;
                state <= S_IDLE;
              end
            end
          endcase
        end
        S_PULSE: begin
          if (tmr_done) begin
            vrst <= '0;
            if (dly == '0) begin
              rom_addr <= rom_addr + ADDR_W'(1);
              state    <= S_FETCH;
            end else begin
              state <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (tmr_done) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign key0  = keys[0];
  assign key1  = keys[1];
  assign key2  = keys[2];
  assign key3  = keys[3];
  assign vrst0 = vrst[0];
  assign vrst1 = vrst[1];
  assign vrst2 = vrst[2];
  assign vrst3 = vrst[3];

endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Score player that drives the synth's per-voice note interface: key0..key3, rst0..rst3 and mute.
- Fetches 16-bit event words from an external synchronous score ROM.
- Retriggers voices with timed reset pulses and spaces events by a tempo tick.
- Sits between the score ROM and the synth core; it is the initiator of every note event the synth plays.

Parameters:
- TICK_DIV, 78125, clk cycles per delay tick (same period as one envelope step).
- RST_LEN, 4, clk cycles a voice reset is held high. Must be ≥4 so every clks phase sees it.
- ADDR_W, 8, score ROM address width.

Ports:
- clk  in  1  system clock
- rsts  in  1  reset, asynchronous, active-high
- start  in  1  begin playback from address 0 (sampled in IDLE only)
- stop  in  1  abort playback
- loop_en  in  1  END event restarts at address 0 instead of stopping
- rom_addr  out  ADDR_W  score address (registered)
- rom_data  in  16  event word, valid the cycle after rom_addr changes
- key0..key3  out  7 each  voice key numbers
- vrst0..vrst3  out  1 each  voice retrigger pulses, registered and glitch-free
- mute  out  4  per-voice mute
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset values: key* = 0, vrst* = 0, mute = 4'hF, rom_addr = 0, busy = 0, state = IDLE.
- Event word fields:
  - [15:14] op: 00 NOTE, 01 WAIT, 10 MUTE, 11 END.
  - [13:12] voice v.
  - [11:5] key.
  - [4:0] delay d, in ticks.
- States: IDLE, FETCH, DECODE, PULSE, DELAY.
- IDLE: start=1 → rom_addr <= 0, go to FETCH.
- FETCH: lasts one cycle, then DECODE. rom_data is sampled in DECODE.
- DECODE actions by op:
  - NOTE: key_v <= key, vrst_v <= 1, mute[v] <= 0, go to PULSE.
  - WAIT: no outputs change.
  - MUTE: mute[v] <= key[0]; keys and vrst unchanged.
  - END, loop_en=1: rom_addr <= 0, go to FETCH.
  - END, loop_en=0: go to IDLE, mute <= 4'hF.
  - WAIT/MUTE exit: if d=0, rom_addr <= rom_addr+1 and go to FETCH; otherwise go to DELAY.
- PULSE:
  - vrst_v stays high for exactly RST_LEN cycles after the DECODE edge.
  - key_v is already stable on the edge where vrst_v rises.
  - On the deassert edge: if d=0, rom_addr+1 and FETCH; otherwise DELAY.
- DELAY:
  - Lasts exactly d*TICK_DIV cycles; the tick divider restarts on entry.
  - On exit: rom_addr+1, go to FETCH.
- Latency and spacing:
  - start sampled → first event's outputs 2 cycles later.
  - NOTE-to-next-event spacing = RST_LEN + d*TICK_DIV + 2 cycles.
  - WAIT/MUTE spacing = d*TICK_DIV + 2 cycles.
- rom_addr wraps from 2^ADDR_W−1 to 0 with no special action.
- stop=1 in any non-IDLE state, on the next edge:
  - All vrst* <= 0, mute <= 4'hF, go to IDLE.
  - key* and rom_addr hold their values.
- start while busy is ignored. start and stop together in IDLE: stop wins, stay in IDLE.
- Only one vrst is ever high at a time.
- rsts mid-operation: all outputs return to their reset values immediately.

Decomposition:
- seq_pkg holds the op codes, field bit positions, state encoding and the RST_LEN minimum check.
- One sub-module, seq_delay_timer:
  - Inputs: load, d.
  - Counts d*TICK_DIV cycles and raises done.
  - Also reused as the PULSE counter with load value RST_LEN.

Test Plan (TICK_DIV=4, RST_LEN=4):
- Reset:
  - Assert rsts mid-DELAY → key*=0, vrst*=0, mute=F, busy=0, rom_addr=0 immediately.
- Single note:
  - Score: ROM[0]=NOTE v1 key 60 d=2, ROM[1]=END; loop_en=0; start at edge 0.
  - key1=60 and vrst1 high from edge 2 to edge 6; mute[1]=0.
  - END decoded at edge 16 → mute=F, busy=0, IDLE.
- Loop:
  - Score: ROM[0]=NOTE v0 key 69 d=0, ROM[1]=END; loop_en=1.
  - vrst0 rises every 8 cycles, each pulse 4 cycles wide; busy stays 1.
- Mute control:
  - Score: MUTE v2 key[0]=0 d=0, then MUTE v2 key[0]=1 d=1, then END.
  - mute[2] clears at edge 2 and sets at edge 4; END decoded at edge 10.
- Stop and restart:
  - stop during PULSE → vrst low and mute=F on the next edge, busy=0.
  - start in the same cycle as stop is ignored.
  - A later start refetches from rom_addr=0.
- Address wrap:
  - 256 WAIT d=0 events, no END.
  - rom_addr goes 255→0, playback continues, busy=1 throughout, and no voice output changes.
